// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: quadrature DDS with phase offset, edge sync and linear chirp sweep
module dds_sweep_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [PHASE_W-1:0]      inc_in,
  input  logic                    inc_load,
  input  logic [PHASE_W-1:0]      phase_off,
  input  logic [PHASE_W-1:0]      sweep_step,
  input  logic [PHASE_W-1:0]      sweep_min,
  input  logic [PHASE_W-1:0]      sweep_max,
  input  logic                    sync_in,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic                    valid_out,
  output logic                    wrap_out,
  output logic                    sweep_wrap
);
  localparam int  N  = 2 ** (ADDR_W - 2);
  localparam int  Q  = N + 1;
  localparam real FS = 2.0 ** (OUT_W - 1) - 1.0;
  localparam real PI = 3.14159265358979323846;
  logic [OUT_W-1:0]   rom [Q];
  logic [PHASE_W-1:0] acc, inc_reg, phase;
  logic [PHASE_W:0]   acc_sum, n_sum;
  logic               sync_q, sync_rise, sweep_over;
  logic [ADDR_W-1:0]  s_idx, c_idx;
  logic [ADDR_W-2:0]  s1_sa, s1_ca;
  logic               s1_sn, s1_cn, s2_sn, s2_cn, v1, v2;
  logic [OUT_W-1:0]   s2_sv, s2_cv;
  // quarter-wave table, endpoints included so index N reads full scale
  for (genvar k = 0; k < Q; k++) begin : g_rom
    assign rom[k] = OUT_W'($rtoi(FS * $sin(PI * k / (2.0 * N)) + 0.5));
  end
  function automatic logic [ADDR_W-2:0] fold(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-2] ? (ADDR_W-1)'(N) - {1'b0, a[ADDR_W-3:0]} : {1'b0, a[ADDR_W-3:0]};
  endfunction
  always_comb begin
    sync_rise  = sync_in & ~sync_q;
    acc_sum    = {1'b0, acc} + {1'b0, inc_reg};
    n_sum      = {1'b0, inc_reg} + {1'b0, sweep_step};
    sweep_over = n_sum > {1'b0, sweep_max};
    phase      = acc + phase_off;
    s_idx      = phase[PHASE_W-1 -: ADDR_W];
    c_idx      = s_idx + ADDR_W'(N);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 1'b0;
      acc        <= '0;
      inc_reg    <= '0;
      wrap_out   <= 1'b0;
      sweep_wrap <= 1'b0;
    end else begin
      sync_q     <= sync_in;
      acc        <= sync_rise ? '0 : en ? acc_sum[PHASE_W-1:0] : acc;
      wrap_out   <= ~sync_rise & en & acc_sum[PHASE_W];
      inc_reg    <= inc_load ? inc_in :
                    (sync_rise & mode) ? sweep_min :
                    (en & mode) ? (sweep_over ? sweep_min : n_sum[PHASE_W-1:0]) : inc_reg;
      sweep_wrap <= ~inc_load & ~sync_rise & en & mode & sweep_over;
    end
  end
  // three-stage sample pipeline: fold/index, table read, sign
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sa     <= '0;
      s1_ca     <= '0;
      s1_sn     <= 1'b0;
      s1_cn     <= 1'b0;
      s2_sv     <= '0;
      s2_cv     <= '0;
      s2_sn     <= 1'b0;
      s2_cn     <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      s1_sa     <= fold(s_idx);
      s1_ca     <= fold(c_idx);
      s1_sn     <= s_idx[ADDR_W-1];
      s1_cn     <= c_idx[ADDR_W-1];
      s2_sv     <= rom[s1_sa];
      s2_cv     <= rom[s1_ca];
      s2_sn     <= s1_sn;
      s2_cn     <= s1_cn;
      v1        <= en;
      v2        <= v1;
      valid_out <= v2;
      sin_out   <= s2_sn ? -s2_sv : s2_sv;
      cos_out   <= s2_cn ? -s2_cv : s2_cv;
    end
  end
endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: directed checks of dds_sweep_gen at default widths
module tb_dds_sweep_gen;
  logic clk = 0, rst = 0, en = 0, mode = 0, inc_load = 0, sync_in = 0;
  logic [31:0] inc_in = 0, phase_off = 0, sweep_step = 0, sweep_min = 0, sweep_max = 0;
  logic signed [15:0] sin_out, cos_out;
  logic valid_out, wrap_out, sweep_wrap;
  int checks = 0, errors = 0;

  dds_sweep_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .inc_in(inc_in), .inc_load(inc_load),
    .phase_off(phase_off), .sweep_step(sweep_step), .sweep_min(sweep_min),
    .sweep_max(sweep_max), .sync_in(sync_in), .sin_out(sin_out), .cos_out(cos_out),
    .valid_out(valid_out), .wrap_out(wrap_out), .sweep_wrap(sweep_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // full-wave reference: round-half-away of 32767*sin(2*pi*k/1024)
  function automatic logic signed [15:0] ref_s(input int k);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return 16'(x < 0.0 ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5));
  endfunction

  task automatic do_reset;
    rst = 0; en = 0; mode = 0; inc_load = 0; sync_in = 0;
    inc_in = 0; phase_off = 0; sweep_step = 0; sweep_min = 0; sweep_max = 0;
    tick; tick;
    rst = 1;
  endtask

  task automatic test_reset;
    rst = 0; en = 1; phase_off = 32'h4000_0000; inc_in = 32'h0040_0000; inc_load = 1;
    repeat (3) tick;
    checks++;
    if ({sin_out, cos_out, valid_out, wrap_out, sweep_wrap} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got sin=%0d cos=%0d v=%b w=%b sw=%b want all 0",
               sin_out, cos_out, valid_out, wrap_out, sweep_wrap);
    end
    checks++;
    if (dut.acc !== 32'd0 || dut.inc_reg !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got acc=%0h inc=%0h want 0/0", dut.acc, dut.inc_reg);
    end
    do_reset;
  endtask

  task automatic test_table_sweep;
    do_reset;
    inc_in = 32'h0040_0000; inc_load = 1;
    tick;
    inc_load = 0; en = 1;
    tick; tick;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL table_valid_early got %b want 0", valid_out);
    end
    for (int k = 0; k < 1024; k++) begin
      tick;
      checks++;
      if (sin_out !== ref_s(k) || cos_out !== ref_s(k + 256) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL table k=%0d got sin=%0d cos=%0d v=%b want sin=%0d cos=%0d v=1",
                 k, sin_out, cos_out, valid_out, ref_s(k), ref_s(k + 256));
      end
      if (k % 256 == 0) begin
        checks++;
        if (sin_out !== (k == 256 ? 16'sd32767 : k == 768 ? -16'sd32767 : 16'sd0)) begin
          errors++;
          $display("FAIL table_cardinal k=%0d got %0d", k, sin_out);
        end
      end
    end
    en = 0;
  endtask

  task automatic test_quarter_rate;
    logic signed [15:0] es [4];
    logic signed [15:0] ec [4];
    es = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32767};
    ec = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0};
    do_reset;
    inc_in = 32'h4000_0000; inc_load = 1;
    tick;
    inc_load = 0; en = 1;
    for (int j = 0; j < 12; j++) begin
      tick;
      checks++;
      if (wrap_out !== ((j + 1) % 4 == 0)) begin
        errors++;
        $display("FAIL quarter_wrap j=%0d got %b want %b", j, wrap_out, (j + 1) % 4 == 0);
      end
      if (j >= 2) begin
        checks++;
        if (sin_out !== es[(j - 2) % 4] || cos_out !== ec[(j - 2) % 4]) begin
          errors++;
          $display("FAIL quarter_sample j=%0d got sin=%0d cos=%0d want sin=%0d cos=%0d",
                   j, sin_out, cos_out, es[(j - 2) % 4], ec[(j - 2) % 4]);
        end
      end
    end
    en = 0;
  endtask

  task automatic test_offset_hold;
    do_reset;
    en = 1; phase_off = 32'h4000_0000;
    tick; tick;
    for (int j = 0; j < 3; j++) begin
      tick;
      checks++;
      if (sin_out !== 16'sd32767 || cos_out !== 16'sd0 || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL offset_q1 j=%0d got sin=%0d cos=%0d v=%b want 32767/0/1",
                 j, sin_out, cos_out, valid_out);
      end
    end
    phase_off = 32'h8000_0000;
    tick; tick;
    checks++;
    if (sin_out !== 16'sd32767) begin
      errors++;
      $display("FAIL offset_latency got sin=%0d want 32767", sin_out);
    end
    tick;
    checks++;
    if (sin_out !== 16'sd0 || cos_out !== -16'sd32767) begin
      errors++;
      $display("FAIL offset_half got sin=%0d cos=%0d want 0/-32767", sin_out, cos_out);
    end
    en = 0; phase_off = 32'h4000_0000;
    repeat (3) tick;
    checks++;
    if (sin_out !== 16'sd32767 || cos_out !== 16'sd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL offset_hold got sin=%0d cos=%0d v=%b want 32767/0/0",
               sin_out, cos_out, valid_out);
    end
  endtask

  task automatic test_chirp;
    logic [31:0] ei [6];
    logic        ew [6];
    ei = '{32'd1310720, 32'd1572864, 32'd1835008, 32'd2097152, 32'd1048576, 32'd1310720};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset;
    mode = 1; sweep_min = 32'h0010_0000; sweep_max = 32'h0020_0000; sweep_step = 32'h0004_0000;
    inc_in = 32'h0010_0000; inc_load = 1;
    tick;
    inc_load = 0; en = 1;
    for (int j = 0; j < 6; j++) begin
      tick;
      checks++;
      if (dut.inc_reg !== ei[j] || sweep_wrap !== ew[j]) begin
        errors++;
        $display("FAIL chirp_step j=%0d got inc=%0d sw=%b want inc=%0d sw=%b",
                 j, dut.inc_reg, sweep_wrap, ei[j], ew[j]);
      end
      if (j == 4) begin
        checks++;
        if (dut.acc !== 32'd7864320) begin
          errors++;
          $display("FAIL chirp_acc got %0d want 7864320", dut.acc);
        end
      end
    end
    en = 0; sweep_max = 32'hFFFF_FFFF; sweep_step = 32'h8000_0000;
    inc_in = 32'h8000_0000; inc_load = 1;
    tick;
    inc_load = 0; en = 1;
    tick;
    checks++;
    if (dut.inc_reg !== 32'h0010_0000 || sweep_wrap !== 1'b1) begin
      errors++;
      $display("FAIL chirp_carry got inc=%0h sw=%b want 100000/1", dut.inc_reg, sweep_wrap);
    end
    en = 0; mode = 0;
  endtask

  task automatic test_sync;
    do_reset;
    inc_in = 32'h0040_0000; inc_load = 1;
    tick;
    inc_load = 0; en = 1;
    repeat (10) tick;
    sync_in = 1;
    tick;
    checks++;
    if (dut.acc !== 32'd0) begin
      errors++;
      $display("FAIL sync_clear got acc=%0h want 0", dut.acc);
    end
    tick;
    checks++;
    if (dut.acc !== 32'h0040_0000) begin
      errors++;
      $display("FAIL sync_held1 got acc=%0h want 400000", dut.acc);
    end
    tick;
    checks++;
    if (dut.acc !== 32'h0080_0000) begin
      errors++;
      $display("FAIL sync_held2 got acc=%0h want 800000", dut.acc);
    end
    tick;
    checks++;
    if (sin_out !== 16'sd0) begin
      errors++;
      $display("FAIL sync_sin0 got %0d want 0", sin_out);
    end
    tick;
    checks++;
    if (sin_out !== ref_s(1)) begin
      errors++;
      $display("FAIL sync_sin1 got %0d want %0d", sin_out, ref_s(1));
    end
    sync_in = 0;
    tick;
    mode = 1; sweep_min = 32'h0010_0000; inc_in = 32'h0200_0000; inc_load = 1; sync_in = 1;
    tick;
    checks++;
    if (dut.inc_reg !== 32'h0200_0000 || dut.acc !== 32'd0) begin
      errors++;
      $display("FAIL sync_load got inc=%0h acc=%0h want 2000000/0", dut.inc_reg, dut.acc);
    end
    inc_load = 0; sync_in = 0;
    tick;
    sync_in = 1;
    tick;
    checks++;
    if (dut.inc_reg !== 32'h0010_0000) begin
      errors++;
      $display("FAIL sync_sweep_min got inc=%0h want 100000", dut.inc_reg);
    end
    sync_in = 0; mode = 0; en = 0;
  endtask

  task automatic test_async_reset;
    do_reset;
    mode = 1; sweep_min = 32'h0010_0000; sweep_max = 32'h0020_0000; sweep_step = 32'h0004_0000;
    inc_in = 32'h0010_0000; inc_load = 1; phase_off = 32'h4000_0000;
    tick;
    inc_load = 0; en = 1;
    repeat (6) tick;
    checks++;
    if (valid_out !== 1'b1 || sin_out === 16'sd0) begin
      errors++;
      $display("FAIL areset_pre got v=%b sin=%0d want 1/nonzero", valid_out, sin_out);
    end
    #3 rst = 0;
    #1;
    checks++;
    if ({sin_out, cos_out, valid_out, wrap_out, sweep_wrap} !== 35'd0) begin
      errors++;
      $display("FAIL areset_async got sin=%0d cos=%0d v=%b w=%b sw=%b want all 0",
               sin_out, cos_out, valid_out, wrap_out, sweep_wrap);
    end
    rst = 1; mode = 0; phase_off = 0;
    tick;
    checks++;
    if (dut.acc !== 32'd0 || dut.inc_reg !== 32'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_restart got acc=%0h inc=%0h v=%b want 0/0/0",
               dut.acc, dut.inc_reg, valid_out);
    end
    tick;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_valid_early got %b want 0", valid_out);
    end
    tick;
    checks++;
    if (valid_out !== 1'b1 || sin_out !== 16'sd0) begin
      errors++;
      $display("FAIL areset_valid got v=%b sin=%0d want 1/0", valid_out, sin_out);
    end
    en = 0;
  endtask

  initial begin
    test_reset;
    test_table_sweep;
    test_quarter_rate;
    test_offset_hold;
    test_chirp;
    test_sync;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
